// File: rtl/io_seq_checker.sv
// On-chip monitor for the IO-port walking pattern: 1..NUM_COUNT, all-ones, zero.
// Synchronizes and debounces the pad bus, then tracks the expected sequence.
module io_seq_checker #(
  parameter int WIDTH          = 8,
  parameter int NUM_COUNT      = 10,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 25000
) (
  input  logic                               clock,
  input  logic                               resetb,
  input  logic                               enable,
  input  logic [WIDTH-1:0]                   io_in,
  output logic [$clog2(NUM_COUNT+3)-1:0]     step,
  output logic [WIDTH-1:0]                   last_value,
  output logic                               done,
  output logic                               pass,
  output logic                               fail,
  output logic [1:0]                         fail_code
);

  localparam int SW = $clog2(NUM_COUNT + 3);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_RUN   = 3'd2,
    S_PASS  = 3'd3,
    S_FAIL  = 3'd4
  } state_t;

  state_t          state_r;
  logic [WIDTH-1:0] sync1_r;
  logic [WIDTH-1:0] sync2_r;
  logic [CW-1:0]    stab_r;
  logic [TW-1:0]    tmo_r;
  logic [SW-1:0]    step_r;
  logic [WIDTH-1:0] last_value_r;
  logic             done_r;
  logic             pass_r;
  logic             fail_r;
  logic [1:0]       fail_code_r;
  logic             accept_s;
  logic             timeout_hit_s;

  function automatic logic [WIDTH-1:0] expected_value(input logic [SW-1:0] s);
    logic [WIDTH-1:0] v;
    if (s < SW'(NUM_COUNT)) begin
      v = WIDTH'(s) + WIDTH'(1);
    end else if (s == SW'(NUM_COUNT)) begin
      v = {WIDTH{1'b1}};
    end else begin
      v = {WIDTH{1'b0}};
    end
    return v;
  endfunction

  // A value is accepted once it has been stable long enough and is new.
  assign accept_s      = (stab_r == CW'(STABLE_CYCLES)) && (sync2_r != last_value_r);
  assign timeout_hit_s = (tmo_r >= TW'(TIMEOUT_CYCLES - 1));

  // Two-flop synchronizer and stability counter on the synchronized bus.
  always_ff @(posedge clock) begin
    if (!resetb) begin
      sync1_r <= {WIDTH{1'b0}};
      sync2_r <= {WIDTH{1'b0}};
      stab_r  <= {CW{1'b0}};
    end else begin
      sync1_r <= io_in;
      sync2_r <= sync1_r;
      if (sync1_r != sync2_r) begin
        stab_r <= CW'(1);
      end else if (stab_r != CW'(STABLE_CYCLES)) begin
        stab_r <= stab_r + CW'(1);
      end
    end
  end

  // Sequence-tracking FSM with registered status outputs.
  always_ff @(posedge clock) begin
    if (!resetb || !enable) begin
      state_r      <= S_IDLE;
      tmo_r        <= {TW{1'b0}};
      step_r       <= {SW{1'b0}};
      last_value_r <= {WIDTH{1'b0}};
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
      fail_r       <= 1'b0;
      fail_code_r  <= 2'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          state_r <= S_ARMED;
          tmo_r   <= {TW{1'b0}};
        end
        S_ARMED: begin
          if (accept_s) begin
            last_value_r <= sync2_r;
          end
          // Power-up and idle pad values are ignored until the first 1 arrives.
          if (accept_s && (sync2_r == WIDTH'(1))) begin
            state_r <= S_RUN;
            step_r  <= SW'(1);
            tmo_r   <= {TW{1'b0}};
          end else if (timeout_hit_s && !accept_s) begin
            state_r     <= S_FAIL;
            done_r      <= 1'b1;
            fail_r      <= 1'b1;
            fail_code_r <= 2'd2;
          end else begin
            tmo_r <= tmo_r + TW'(1);
          end
        end
        S_RUN: begin
          if (accept_s) begin
            last_value_r <= sync2_r;
            if (sync2_r == expected_value(step_r)) begin
              step_r <= step_r + SW'(1);
              tmo_r  <= {TW{1'b0}};
              if (step_r == SW'(NUM_COUNT + 1)) begin
                state_r <= S_PASS;
                done_r  <= 1'b1;
                pass_r  <= 1'b1;
              end
            end else begin
              state_r     <= S_FAIL;
              done_r      <= 1'b1;
              fail_r      <= 1'b1;
              fail_code_r <= 2'd1;
            end
          end else if (timeout_hit_s) begin
            state_r     <= S_FAIL;
            done_r      <= 1'b1;
            fail_r      <= 1'b1;
            fail_code_r <= 2'd2;
          end else begin
            tmo_r <= tmo_r + TW'(1);
          end
        end
        S_PASS: begin
          state_r <= S_PASS;
        end
        S_FAIL: begin
          state_r <= S_FAIL;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign step       = step_r;
  assign last_value = last_value_r;
  assign done       = done_r;
  assign pass       = pass_r;
  assign fail       = fail_r;
  assign fail_code  = fail_code_r;

endmodule

// File: tb/tb_io_seq_checker.sv
// Directed bench for io_seq_checker: default instance plus a short-timeout instance.
module tb_io_seq_checker;

  logic       clock = 1'b0;
  logic       resetb;
  logic       enable;
  logic       en_t;
  logic [7:0] io_in;

  logic [3:0] step, step_t;
  logic [7:0] last_value, last_value_t;
  logic       done, pass, fail, done_t, pass_t, fail_t;
  logic [1:0] fail_code, fail_code_t;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  io_seq_checker dut (
    .clock(clock), .resetb(resetb), .enable(enable), .io_in(io_in),
    .step(step), .last_value(last_value), .done(done), .pass(pass),
    .fail(fail), .fail_code(fail_code)
  );

  io_seq_checker #(.TIMEOUT_CYCLES(100)) dut_t (
    .clock(clock), .resetb(resetb), .enable(en_t), .io_in(io_in),
    .step(step_t), .last_value(last_value_t), .done(done_t), .pass(pass_t),
    .fail(fail_t), .fail_code(fail_code_t)
  );

  task automatic do_reset();
    @(negedge clock);
    resetb = 1'b0;
    enable = 1'b0;
    en_t   = 1'b0;
    io_in  = 8'h00;
    repeat (3) @(negedge clock);
    resetb = 1'b1;
    @(negedge clock);
  endtask

  task automatic hold(input logic [7:0] v, input int n);
    io_in = v;
    repeat (n) @(negedge clock);
  endtask

  task automatic drive_range(input int first, input int last);
    for (int v = first; v <= last; v++) begin
      hold(8'(v), 10);
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    resetb = 1'b0;
    enable = 1'b1;
    io_in  = 8'h01;
    repeat (2) @(negedge clock);
    checks++; if (step !== 4'd0) begin failures++; $display("FAIL reset_step got=%0d exp=0", step); end
    checks++; if (last_value !== 8'h00) begin failures++; $display("FAIL reset_last got=%h exp=00", last_value); end
    checks++; if ({done, pass, fail} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {done, pass, fail}); end
    checks++; if (fail_code !== 2'd0) begin failures++; $display("FAIL reset_code got=%0d exp=0", fail_code); end
    do_reset();
  endtask

  task automatic test_clean_sequence();
    do_reset();
    enable = 1'b1;
    @(negedge clock);
    drive_range(1, 10);
    hold(8'hFF, 10);
    checks++; if (step !== 4'd11) begin failures++; $display("FAIL clean_step_ff got=%0d exp=11", step); end
    hold(8'h00, 5);
    checks++; if (pass !== 1'b0) begin failures++; $display("FAIL clean_pass_early got=%b exp=0", pass); end
    @(negedge clock);
    checks++; if (pass !== 1'b1) begin failures++; $display("FAIL clean_pass got=%b exp=1", pass); end
    checks++; if ({done, fail} !== 2'b10) begin failures++; $display("FAIL clean_done_fail got=%b exp=10", {done, fail}); end
    checks++; if (fail_code !== 2'd0) begin failures++; $display("FAIL clean_code got=%0d exp=0", fail_code); end
    checks++; if (step !== 4'd12) begin failures++; $display("FAIL clean_step got=%0d exp=12", step); end
    checks++; if (last_value !== 8'h00) begin failures++; $display("FAIL clean_last got=%h exp=00", last_value); end
    hold(8'h05, 12);
    checks++; if ({pass, fail, step} !== {1'b1, 1'b0, 4'd12}) begin failures++; $display("FAIL clean_sticky got=%b%b/%0d exp=10/12", pass, fail, step); end
  endtask

  task automatic test_glitch();
    do_reset();
    enable = 1'b1;
    @(negedge clock);
    drive_range(1, 3);
    hold(8'h07, 3);
    hold(8'h03, 10);
    checks++; if ({fail, step, last_value} !== {1'b0, 4'd3, 8'h03}) begin failures++; $display("FAIL glitch_mid got=%b/%0d/%h exp=0/3/03", fail, step, last_value); end
    drive_range(4, 10);
    hold(8'hFF, 10);
    hold(8'h00, 10);
    checks++; if ({pass, fail} !== 2'b10) begin failures++; $display("FAIL glitch_pass got=%b exp=10", {pass, fail}); end
  endtask

  task automatic test_wrong_value();
    do_reset();
    enable = 1'b1;
    @(negedge clock);
    drive_range(1, 3);
    hold(8'h05, 10);
    checks++; if ({done, fail, pass} !== 3'b110) begin failures++; $display("FAIL wrong_flags got=%b exp=110", {done, fail, pass}); end
    checks++; if (fail_code !== 2'd1) begin failures++; $display("FAIL wrong_code got=%0d exp=1", fail_code); end
    checks++; if (step !== 4'd3) begin failures++; $display("FAIL wrong_step got=%0d exp=3", step); end
    checks++; if (last_value !== 8'h05) begin failures++; $display("FAIL wrong_last got=%h exp=05", last_value); end
    hold(8'h04, 10);
    checks++; if ({fail, step, last_value} !== {1'b1, 4'd3, 8'h05}) begin failures++; $display("FAIL wrong_sticky got=%b/%0d/%h exp=1/3/05", fail, step, last_value); end
  endtask

  task automatic test_timeout();
    do_reset();
    en_t = 1'b1;
    repeat (2) @(negedge clock);
    hold(8'h01, 6);
    checks++; if (step_t !== 4'd1) begin failures++; $display("FAIL tmo_accept got=%0d exp=1", step_t); end
    // accept at posedge 6 after the change; timeout lands 100 edges later
    repeat (99) @(negedge clock);
    checks++; if (fail_t !== 1'b0) begin failures++; $display("FAIL tmo_early got=%b exp=0", fail_t); end
    @(negedge clock);
    checks++; if ({fail_t, pass_t, done_t} !== 3'b101) begin failures++; $display("FAIL tmo_flags got=%b exp=101", {fail_t, pass_t, done_t}); end
    checks++; if (fail_code_t !== 2'd2) begin failures++; $display("FAIL tmo_code got=%0d exp=2", fail_code_t); end
    checks++; if (step_t !== 4'd1) begin failures++; $display("FAIL tmo_step got=%0d exp=1", step_t); end
    en_t = 1'b0;
  endtask

  task automatic test_arming();
    do_reset();
    enable = 1'b1;
    hold(8'h00, 50);
    hold(8'h3C, 50);
    checks++; if ({done, step, last_value} !== {1'b0, 4'd0, 8'h3C}) begin failures++; $display("FAIL arm_idle got=%b/%0d/%h exp=0/0/3c", done, step, last_value); end
    drive_range(1, 10);
    hold(8'hFF, 10);
    hold(8'h00, 10);
    checks++; if ({pass, fail} !== 2'b10) begin failures++; $display("FAIL arm_pass got=%b exp=10", {pass, fail}); end
  endtask

  task automatic test_abort();
    do_reset();
    enable = 1'b1;
    @(negedge clock);
    drive_range(1, 5);
    checks++; if (step !== 4'd5) begin failures++; $display("FAIL abort_pre got=%0d exp=5", step); end
    enable = 1'b0;
    @(negedge clock);
    checks++; if ({step, done, last_value} !== {4'd0, 1'b0, 8'h00}) begin failures++; $display("FAIL abort_disable got=%0d/%b/%h exp=0/0/00", step, done, last_value); end
    enable = 1'b1;
    repeat (10) @(negedge clock);
    drive_range(1, 10);
    hold(8'hFF, 10);
    hold(8'h00, 10);
    checks++; if ({pass, fail, step} !== {1'b1, 1'b0, 4'd12}) begin failures++; $display("FAIL abort_rerun got=%b%b/%0d exp=10/12", pass, fail, step); end
    do_reset();
    enable = 1'b1;
    @(negedge clock);
    drive_range(1, 7);
    checks++; if (step !== 4'd7) begin failures++; $display("FAIL abort_step7 got=%0d exp=7", step); end
    resetb = 1'b0;
    @(negedge clock);
    resetb = 1'b1;
    checks++; if ({step, last_value, done, pass, fail, fail_code} !== {4'd0, 8'h00, 3'b000, 2'd0}) begin failures++; $display("FAIL abort_reset got=%0d/%h/%b%b%b/%0d exp=0/00/000/0", step, last_value, done, pass, fail, fail_code); end
  endtask

  initial begin
    resetb = 1'b0;
    enable = 1'b0;
    en_t   = 1'b0;
    io_in  = 8'h00;
    test_reset();
    test_clean_sequence();
    test_glitch();
    test_wrong_value();
    test_timeout();
    test_arming();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/io_seq_checker.md
Name: io_seq_checker

Overview:
- Synthesizable on-chip monitor for the user-project IO-ports test: it watches the 8-bit mprj_io[7:0] output pattern and reports pass/fail in hardware.
- Sits directly downstream of the GPIO output pads, i.e. it consumes what the firmware-driven port produces.
- Expected sequence: 0x01, 0x02, … NUM_COUNT, then all-ones, then all-zeros.
- Used in gate-level/FPGA bring-up where a behavioural bench monitor is unavailable.

Parameters:
- WIDTH, 8, observed bus width.
- NUM_COUNT, 10, last value of the incrementing phase (values 1..NUM_COUNT); must be < 2^WIDTH-1.
- STABLE_CYCLES, 4, consecutive identical synchronized samples required to accept a value (≥1).
- TIMEOUT_CYCLES, 25000, maximum cycles allowed between accepted steps.

Ports:
- clock  input  1  single clock.
- resetb  input  1  reset, synchronous, active-low.
- enable  input  1  arms the checker; low forces IDLE.
- io_in  input  WIDTH  observed pad values, asynchronous to clock.
- step  output  $clog2(NUM_COUNT+3)  index of next expected element.
- last_value  output  WIDTH  most recently accepted value.
- done  output  1  high in PASS or FAIL.
- pass  output  1  sequence completed correctly.
- fail  output  1  sequence error or timeout.
- fail_code  output  2  0=none, 1=wrong value, 2=timeout.

Behaviour:
- Reset, sampled on a clock edge with resetb=0:
  - step=0, last_value=0, done=pass=fail=0, fail_code=0, state IDLE.
  - Synchronizer, stability and timeout counters are cleared.
- Input path:
  - 2-flop synchronizer on io_in, then a stability filter.
  - Stability counter increments while the sync output is unchanged (saturating at STABLE_CYCLES) and reloads to 1 on any change.
  - An accept pulse is generated when the counter reaches STABLE_CYCLES and the value differs from last_value. It fires exactly once per new stable value.
  - A value held fewer than STABLE_CYCLES samples is never accepted.
- Latency: an io_in change held steady updates step/last_value/pass/fail STABLE_CYCLES+2 edges after the first edge that samples it.
- Expected value for step s:
  - s+1 for s < NUM_COUNT.
  - all-ones for s = NUM_COUNT.
  - zero for s = NUM_COUNT+1.
- States:
  - IDLE: enable=0. All outputs are held at their reset values. enable=1 → ARMED, and the timeout counter clears.
  - ARMED (step=0):
    - Accepted value == 1 → RUN, step=1.
    - Any other accepted value is ignored: power-up and default pad values must not fail.
  - RUN:
    - Accepted value == expected → step+1 and the timeout counter clears.
    - If that value was the zero terminator → PASS.
    - Accepted value ≠ expected → FAIL, fail_code=1, step frozen at the failing index.
  - PASS: done=1, pass=1. Sticky.
  - FAIL: done=1, fail=1. Sticky.
  - enable=0 in any state → IDLE on the next edge, outputs cleared.
- last_value updates on every accept, in ARMED and RUN.
- Timeout:
  - The counter increments every cycle in ARMED and RUN.
  - On reaching TIMEOUT_CYCLES with no accept on that edge → FAIL, fail_code=2.
  - An accept on the same edge wins: step advances and the counter clears.
- pass and fail are mutually exclusive, never both high.
- After PASS/FAIL, further io_in activity has no effect until enable falls or reset.
- Reset mid-run takes priority over everything; the state after reset is identical to the power-on reset state.

Test Plan:
- Clean sequence:
  - Stimulus: enable=1; drive 0x01..0x0A, 0xFF, 0x00, each held 10 cycles.
  - Response: pass=1, done=1, fail_code=0, step=12, last_value=0x00; pass rises 6 edges after 0x00 is applied.
- Glitch rejection:
  - Stimulus: during 0x03 hold, pulse 0x07 for 3 cycles (STABLE_CYCLES=4), then return to 0x03; complete the sequence.
  - Response: no fail, final pass=1.
- Wrong value:
  - Stimulus: 0x01, 0x02, 0x03, then 0x05 held.
  - Response: fail=1, fail_code=1, step=3, last_value=0x05, pass=0.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=100; drive 0x01, then hold it indefinitely.
  - Response: fail=1, fail_code=2, exactly 100 cycles after the 0x01 accept; step=1.
- Arming tolerance:
  - Stimulus: after enable, hold 0x00 then 0x3C for 50 cycles each, then run the full clean sequence.
  - Response: pass=1.
- Abort paths:
  - enable dropped at step=5 → next edge step=0, done=0, last_value=0.
  - Re-enable and run the clean sequence → pass=1.
  - resetb=0 for one edge at step=7 → all outputs at reset values on that edge.
